entropy_health_monitor: RTL

- Sits directly downstream of any entropy source that drives the `entropy_valid`/`entropy_bit` pair (mock or physical RNG).
- Runs two continuous health tests on the raw bit stream: a repetition count test (RCT) and an adaptive proportion test (APT), in the style of SP 800-90B.
- Packs accepted bits into WORD_W-bit words on a valid/ready output.
- Any health failure raises a sticky alarm and suppresses output until software clears it.

---
 rtl/entropy_pkg.sv | 21 ++
 rtl/entropy_packer.sv | 76 +++++++
 rtl/entropy_health_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/entropy_pkg.sv
// Shared constants, status struct and width helper for the entropy health
// monitor and its output packer.
package entropy_pkg;

    localparam int unsigned RCT_CUTOFF_DEF = 8;
    localparam int unsigned APT_WINDOW_DEF = 64;
    localparam int unsigned APT_CUTOFF_DEF = 48;
    localparam int unsigned WORD_W_DEF     = 8;

    typedef struct packed {
        logic rct_fail;
        logic apt_fail;
        logic alarm;
    } health_status_t;

    // Bits needed for a counter that must hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/entropy_packer.sv
// Packs accepted entropy bits LSB-first into words and presents them on a
// valid/ready output register; a flush empties both stages at once.
module entropy_packer
    import entropy_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    input  logic              word_ready_i,
    output logic [WORD_W-1:0] word_data_o,
    output logic              word_valid_o
);

    localparam int unsigned IDX_W = cnt_width(WORD_W);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WORD_W);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              sr_full, out_free, move;
    logic [IDX_W-1:0]  wr_idx;
    logic [WORD_W-1:0] sr_base;

    // Handshake: word_valid_o rises only with a complete word, then word_data_o
    // holds unchanged until a cycle with word_ready_i high; only flush_i may
    // drop word_valid_o without that transfer.
    always_comb begin
        sr_d     = sr_q;
        out_d    = out_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        sr_full  = (idx_q == IDX_FULL);
        out_free = !valid_q || word_ready_i;
        move     = sr_full && out_free;
        wr_idx   = move ? '0 : idx_q;
        sr_base  = move ? '0 : sr_q;

        if (valid_q && word_ready_i) begin
            valid_d = 1'b0;
        end
        if (move) begin
            out_d   = sr_q;
            valid_d = 1'b1;
            sr_d    = '0;
            idx_d   = '0;
        end
        // A full shift register with a busy output stage drops the bit.
        if (bit_valid_i && (!sr_full || move)) begin
            sr_d  = sr_base | (WORD_W'(bit_i) << wr_idx);
            idx_d = wr_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            sr_q    <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign word_data_o  = out_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/entropy_health_monitor.sv
// Runs repetition-count and adaptive-proportion health tests on a raw
// entropy bit stream, packs healthy bits into words, and latches an alarm.
module entropy_health_monitor
    import entropy_pkg::*;
#(
    parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
    parameter int unsigned APT_WINDOW = APT_WINDOW_DEF,
    parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF,
    parameter int unsigned WORD_W     = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              entropy_valid,
    input  logic              entropy_bit,
    input  logic              clear_alarm,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              rct_fail,
    output logic              apt_fail,
    output logic              alarm
);

    localparam int unsigned RCT_W = cnt_width(RCT_CUTOFF);
    localparam int unsigned APT_W = cnt_width(APT_WINDOW);
    localparam logic [RCT_W-1:0] RCT_MAX = RCT_W'(RCT_CUTOFF);
    localparam logic [APT_W-1:0] APT_WIN = APT_W'(APT_WINDOW);
    localparam logic [APT_W-1:0] APT_CUT = APT_W'(APT_CUTOFF);

    logic             last_bit_q, last_bit_d;
    logic             have_last_q, have_last_d;
    logic [RCT_W-1:0] run_q, run_d, run_inc;
    logic             apt_ref_q, apt_ref_d;
    logic [APT_W-1:0] apt_n_q, apt_n_d, apt_n_inc;
    logic [APT_W-1:0] apt_cnt_q, apt_cnt_d, apt_cnt_inc;
    health_status_t   status_q, status_d;
    logic             accept, rct_hit, apt_hit;

    // A sample arriving together with clear_alarm is discarded entirely.
    assign accept      = entropy_valid && !clear_alarm;
    assign run_inc     = run_q + RCT_W'(1);
    assign apt_n_inc   = apt_n_q + APT_W'(1);
    assign apt_cnt_inc = apt_cnt_q + APT_W'(1);

    always_comb begin
        last_bit_d  = last_bit_q;
        have_last_d = have_last_q;
        run_d       = run_q;
        apt_ref_d   = apt_ref_q;
        apt_n_d     = apt_n_q;
        apt_cnt_d   = apt_cnt_q;
        rct_hit     = 1'b0;
        apt_hit     = 1'b0;

        if (accept) begin
            last_bit_d  = entropy_bit;
            have_last_d = 1'b1;
            if (have_last_q && (entropy_bit == last_bit_q)) begin
                if (run_q != RCT_MAX) begin
                    run_d   = run_inc;
                    rct_hit = (run_inc == RCT_MAX);
                end
            end else begin
                run_d = RCT_W'(1);
            end

            // Sample counter at 0 (fresh) or at the window length opens a new window.
            if ((apt_n_q == '0) || (apt_n_q == APT_WIN)) begin
                apt_n_d   = APT_W'(1);
                apt_ref_d = entropy_bit;
                apt_cnt_d = APT_W'(1);
                apt_hit   = (APT_CUT == APT_W'(1));
            end else begin
                apt_n_d = apt_n_inc;
                if ((entropy_bit == apt_ref_q) && (apt_cnt_q != APT_CUT)) begin
                    apt_cnt_d = apt_cnt_inc;
                    apt_hit   = (apt_cnt_inc == APT_CUT);
                end
            end
        end
    end

    always_comb begin
        status_d          = status_q;
        status_d.rct_fail = rct_hit;
        status_d.apt_fail = apt_hit;
        status_d.alarm    = status_q.alarm | rct_hit | apt_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_alarm) begin
            last_bit_q  <= 1'b0;
            have_last_q <= 1'b0;
            run_q       <= '0;
            apt_ref_q   <= 1'b0;
            apt_n_q     <= '0;
            apt_cnt_q   <= '0;
            status_q    <= '0;
        end else begin
            last_bit_q  <= last_bit_d;
            have_last_q <= have_last_d;
            run_q       <= run_d;
            apt_ref_q   <= apt_ref_d;
            apt_n_q     <= apt_n_d;
            apt_cnt_q   <= apt_cnt_d;
            status_q    <= status_d;
        end
    end

    entropy_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (clear_alarm | rct_hit | apt_hit),
        .bit_valid_i  (accept && !status_q.alarm),
        .bit_i        (entropy_bit),
        .word_ready_i (word_ready),
        .word_data_o  (word_data),
        .word_valid_o (word_valid)
    );

    assign rct_fail = status_q.rct_fail;
    assign apt_fail = status_q.apt_fail;
    assign alarm    = status_q.alarm;

endmodule
